// File: rtl/multicycle_controller.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback.
// Moore strobes, memory wait timeout, trap state, retired counter.
module multicycle_controller #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             trap_clear,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             mem2reg,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    C_R, C_I, C_LOAD, C_STORE
  } class_t;

  state_t            st_q, st_d;
  class_t            cls_q, cls_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]        cause_q, cause_d;
  logic              ret;
  logic              wait_hit;
  logic              is_mem;

  // One more idle cycle would make the wait count reach TIMEOUT.
  assign wait_hit = (TIMEOUT > 0) &&
                    (int'(wcnt_q) + 1 >= TIMEOUT);
  assign is_mem   = (cls_q == C_LOAD) ||
                    (cls_q == C_STORE);

  // State, class, wait, cause and retired-count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= S_FETCH;
      cls_q   <= C_R;
      wcnt_q  <= '0;
      cause_q <= 2'b00;
      instret <= '0;
    end else begin
      st_q    <= st_d;
      cls_q   <= cls_d;
      wcnt_q  <= wcnt_d;
      cause_q <= cause_d;
      if (ret) instret <= instret + 1'b1;
    end
  end

  // Next state; wait count is zero outside a stalled access.
  always_comb begin
    st_d    = st_q;
    cls_d   = cls_q;
    cause_d = cause_q;
    wcnt_d  = '0;
    ret     = 1'b0;
    unique case (st_q)
      S_FETCH: begin
        if (mem_ready) begin
          st_d = S_DECODE;
        end else if (wait_hit) begin
          st_d    = S_TRAP;
          cause_d = 2'b10;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        st_d = S_EXECUTE;
        case (opcode)
          7'b0110011: cls_d = C_R;
          7'b0010011: cls_d = C_I;
          7'b0000011: cls_d = C_LOAD;
          7'b0100011: cls_d = C_STORE;
          default: begin
            st_d    = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_EXECUTE: begin
        st_d = is_mem ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            st_d = S_FETCH;
            ret  = 1'b1;
          end else begin
            st_d = S_WRITEBACK;
          end
        end else if (wait_hit) begin
          st_d    = S_TRAP;
          cause_d = 2'b10;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WRITEBACK: begin
        st_d = S_FETCH;
        ret  = 1'b1;
      end
      S_TRAP: begin
        if (trap_clear) begin
          st_d    = S_FETCH;
          cause_d = 2'b00;
        end
      end
      default: begin
        st_d    = S_TRAP;
        cause_d = 2'b01;
      end
    endcase
  end

  // Moore strobes from state, latched class and mem_ready.
  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_src   = 1'b0;
    mem2reg   = 1'b0;
    alu_op    = 2'b00;
    unique case (st_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
      end
      S_EXECUTE: begin
        alu_src = (cls_q != C_R);
        alu_op  = is_mem ? 2'b00 : 2'b10;
      end
      S_MEMORY: begin
        alu_src   = 1'b1;
        mem_read  = (cls_q == C_LOAD);
        mem_write = (cls_q == C_STORE);
        pc_write  = (cls_q == C_STORE) && mem_ready;
      end
      S_WRITEBACK: begin
        alu_src   = (cls_q != C_R);
        alu_op    = is_mem ? 2'b00 : 2'b10;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        mem2reg   = (cls_q == C_LOAD);
      end
      default: ;
    endcase
  end

  assign state      = st_q;
  assign trap       = (st_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// strb = {pc,ir,reg,mrd,mwr,asrc,m2r,aop[1:0]}.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       trap_clear;
  logic       pc_write, ir_write, reg_write;
  logic       mem_read, mem_write;
  logic       alu_src, mem2reg;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] instret;
  logic [8:0] strb;

  int errors = 0;
  int checks = 0;

  assign strb = {pc_write, ir_write, reg_write,
                 mem_read, mem_write, alu_src,
                 mem2reg, alu_op};

  always #5 clk = ~clk;

  multicycle_controller #(
    .CNT_W(4),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .mem_ready(mem_ready),
    .trap_clear(trap_clear),
    .pc_write(pc_write),
    .ir_write(ir_write),
    .reg_write(reg_write),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .alu_src(alu_src),
    .mem2reg(mem2reg),
    .alu_op(alu_op),
    .state(state),
    .trap(trap),
    .trap_cause(trap_cause),
    .instret(instret)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    opcode = OP_R;
    mem_ready = 1'b0;
    trap_clear = 1'b0;
    #3;
    checks++;
    if ({state, strb} !== {3'd0, 9'b000100000}) begin
      errors++;
      $display("FAIL rst_out got st=%0d strb=%b exp st=0 strb=000100000", state, strb);
    end
    checks++;
    if ({trap, trap_cause, instret} !== 7'd0) begin
      errors++;
      $display("FAIL rst_regs got trap=%b cause=%b ir=%0d exp 0/00/0", trap, trap_cause, instret);
    end
    step();
    step();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL rst_hold got st=%0d exp 0", state);
    end
    reset = 1'b1;
  endtask

  task automatic test_rtype();
    opcode = OP_R;
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({state, strb} !== {3'd0, 9'b010100000}) begin
      errors++;
      $display("FAIL r_fetch got st=%0d strb=%b exp st=0 strb=010100000", state, strb);
    end
    step();
    checks++;
    if ({state, strb} !== {3'd1, 9'b000000000}) begin
      errors++;
      $display("FAIL r_decode got st=%0d strb=%b exp st=1 strb=0", state, strb);
    end
    step();
    checks++;
    if ({state, strb} !== {3'd2, 9'b000000010}) begin
      errors++;
      $display("FAIL r_exec got st=%0d strb=%b exp st=2 strb=000000010", state, strb);
    end
    step();
    checks++;
    if ({state, strb} !== {3'd4, 9'b101000010}) begin
      errors++;
      $display("FAIL r_wb got st=%0d strb=%b exp st=4 strb=101000010", state, strb);
    end
    step();
    checks++;
    if ({state, instret} !== {3'd0, 4'd1}) begin
      errors++;
      $display("FAIL r_retire got st=%0d ir=%0d exp st=0 ir=1", state, instret);
    end
  endtask

  task automatic test_itype();
    opcode = OP_I;
    mem_ready = 1'b1;
    step();
    step();
    checks++;
    if ({state, strb} !== {3'd2, 9'b000001010}) begin
      errors++;
      $display("FAIL i_exec got st=%0d strb=%b exp st=2 strb=000001010", state, strb);
    end
    step();
    checks++;
    if ({state, strb} !== {3'd4, 9'b101001010}) begin
      errors++;
      $display("FAIL i_wb got st=%0d strb=%b exp st=4 strb=101001010", state, strb);
    end
    step();
    checks++;
    if (instret !== 4'd2) begin
      errors++;
      $display("FAIL i_retire got ir=%0d exp 2", instret);
    end
  endtask

  task automatic test_load_wait();
    opcode = OP_LD;
    mem_ready = 1'b1;
    step();
    step();
    checks++;
    if ({state, strb} !== {3'd2, 9'b000001000}) begin
      errors++;
      $display("FAIL ld_exec got st=%0d strb=%b exp st=2 strb=000001000", state, strb);
    end
    mem_ready = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin
        mem_ready = 1'b1;
        #1;
      end
      checks++;
      if ({state, strb} !== {3'd3, 9'b000101000}) begin
        errors++;
        $display("FAIL ld_mem%0d got st=%0d strb=%b exp st=3 strb=000101000", i, state, strb);
      end
      if (i < 4) step();
    end
    step();
    checks++;
    if ({state, strb, instret} !== {3'd4, 9'b101001100, 4'd2}) begin
      errors++;
      $display("FAIL ld_wb got st=%0d strb=%b ir=%0d exp st=4 strb=101001100 ir=2", state, strb, instret);
    end
    step();
    checks++;
    if ({state, instret} !== {3'd0, 4'd3}) begin
      errors++;
      $display("FAIL ld_retire got st=%0d ir=%0d exp st=0 ir=3", state, instret);
    end
  endtask

  task automatic test_store();
    opcode = OP_ST;
    mem_ready = 1'b1;
    step();
    step();
    checks++;
    if ({state, strb} !== {3'd2, 9'b000001000}) begin
      errors++;
      $display("FAIL st_exec got st=%0d strb=%b exp st=2 strb=000001000", state, strb);
    end
    step();
    checks++;
    if ({state, strb} !== {3'd3, 9'b100011000}) begin
      errors++;
      $display("FAIL st_mem got st=%0d strb=%b exp st=3 strb=100011000", state, strb);
    end
    step();
    checks++;
    if ({state, instret} !== {3'd0, 4'd4}) begin
      errors++;
      $display("FAIL st_retire got st=%0d ir=%0d exp st=0 ir=4", state, instret);
    end
  endtask

  task automatic test_illegal();
    opcode = OP_BAD;
    mem_ready = 1'b1;
    step();
    step();
    checks++;
    if ({state, trap, trap_cause, strb} !== {3'd7, 1'b1, 2'b01, 9'd0}) begin
      errors++;
      $display("FAIL ill_trap got st=%0d trap=%b cause=%b strb=%b exp 7/1/01/0", state, trap, trap_cause, strb);
    end
    mem_ready = 1'b0;
    step();
    checks++;
    if ({state, trap_cause} !== {3'd7, 2'b01}) begin
      errors++;
      $display("FAIL ill_hold got st=%0d cause=%b exp 7/01", state, trap_cause);
    end
    trap_clear = 1'b1;
    step();
    trap_clear = 1'b0;
    checks++;
    if ({state, trap, trap_cause, instret} !== {3'd0, 1'b0, 2'b00, 4'd4}) begin
      errors++;
      $display("FAIL ill_clear got st=%0d trap=%b cause=%b ir=%0d exp 0/0/00/4", state, trap, trap_cause, instret);
    end
  endtask

  task automatic test_timeout();
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL to_wait got st=%0d exp 0", state);
    end
    step();
    checks++;
    if ({state, trap, trap_cause, strb} !== {3'd7, 1'b1, 2'b10, 9'd0}) begin
      errors++;
      $display("FAIL to_trap got st=%0d trap=%b cause=%b strb=%b exp 7/1/10/0", state, trap, trap_cause, strb);
    end
    trap_clear = 1'b1;
    step();
    trap_clear = 1'b0;
    opcode = OP_R;
    for (int i = 0; i < 14; i++) step();
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({state, ir_write} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL to_edge got st=%0d irw=%b exp 0/1", state, ir_write);
    end
    step();
    checks++;
    if ({state, trap, trap_cause} !== {3'd1, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL to_win got st=%0d trap=%b cause=%b exp 1/0/00", state, trap, trap_cause);
    end
    step();
    step();
    step();
    checks++;
    if ({state, instret} !== {3'd0, 4'd5}) begin
      errors++;
      $display("FAIL to_retire got st=%0d ir=%0d exp 0/5", state, instret);
    end
  endtask

  task automatic test_reset_mid();
    opcode = OP_LD;
    mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    step();
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL mid_mem got st=%0d exp 3", state);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({state, instret, strb} !== {3'd0, 4'd0, 9'b000100000}) begin
      errors++;
      $display("FAIL mid_async got st=%0d ir=%0d strb=%b exp 0/0/000100000", state, instret, strb);
    end
    step();
    reset = 1'b1;
  endtask

  task automatic test_wrap();
    opcode = OP_R;
    mem_ready = 1'b1;
    for (int n = 0; n < 15; n++) begin
      for (int c = 0; c < 4; c++) step();
    end
    checks++;
    if ({state, instret} !== {3'd0, 4'd15}) begin
      errors++;
      $display("FAIL wrap_15 got st=%0d ir=%0d exp 0/15", state, instret);
    end
    for (int c = 0; c < 4; c++) step();
    checks++;
    if ({state, instret} !== {3'd0, 4'd0}) begin
      errors++;
      $display("FAIL wrap_0 got st=%0d ir=%0d exp 0/0", state, instret);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load_wait();
    test_store();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 Parameter TIMEOUT, default 15: maximum wait cycles for mem_ready in FETCH or MEMORY; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 opcode  input  7  instruction opcode field, sampled in DECODE.
REQ-006 mem_ready  input  1  memory handshake completion for the current fetch, load or store.
REQ-007 trap_clear  input  1  leaves TRAP; ignored in every other state.
REQ-008 pc_write, ir_write, reg_write, mem_read, mem_write  output  1 each  datapath strobes.
REQ-009 alu_src, mem2reg  output  1 each  datapath mux selects.
REQ-010 alu_op  output  2  ALU controller class: 00 add (address), 10 funct-decoded.
REQ-011 state  output  3  current state encoding.
REQ-012 trap  output  1  high while in TRAP.
REQ-013 trap_cause  output  2  01 illegal opcode, 10 memory timeout, 00 none.
REQ-014 instret  output  CNT_W  count of retired instructions.

Function
REQ-015 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=7; codes 5 and 6 SHALL go to TRAP with cause 01 on the next edge.
REQ-016 Outputs SHALL be Moore: a function of state, the latched class and mem_ready only; every strobe not listed for a state SHALL be 0.
REQ-017 FETCH: mem_read=1 and ir_write=mem_ready; on mem_ready the next state SHALL be DECODE.
REQ-018 DECODE: opcode SHALL be latched into a class register: 0110011=R, 0010011=I, 0000011=LOAD, 0100011=STORE; any other value SHALL go to TRAP with trap_cause=01, otherwise EXECUTE.
REQ-019 EXECUTE for R: alu_src=0, alu_op=10. For I: alu_src=1, alu_op=10. R and I SHALL go to WRITEBACK.
REQ-020 EXECUTE for LOAD/STORE: alu_src=1, alu_op=00; next state SHALL be MEMORY.
REQ-021 MEMORY: alu_src=1, alu_op=00; LOAD asserts mem_read, STORE asserts mem_write; each is held until mem_ready.
REQ-022 MEMORY with mem_ready: LOAD SHALL go to WRITEBACK; STORE SHALL assert pc_write the same cycle, increment instret and go to FETCH.
REQ-023 WRITEBACK: reg_write=1, pc_write=1, mem2reg=1 only for LOAD, alu_op/alu_src held as in EXECUTE; instret SHALL increment and next state SHALL be FETCH.
REQ-024 Latency without wait states SHALL be: R/I 4 cycles, LOAD 5 cycles, STORE 4 cycles; each mem_ready-low cycle adds one cycle.
REQ-025 The wait counter SHALL clear on entry to FETCH/MEMORY and on mem_ready, and increment per mem_ready-low cycle; when it reaches TIMEOUT (TIMEOUT>0), the next state SHALL be TRAP with cause 10 and strobes deasserted.
REQ-026 mem_ready on the same cycle the counter reaches TIMEOUT SHALL win: the access completes, no trap.
REQ-027 TRAP: all strobes 0, trap=1, trap_cause held; trap_clear SHALL go to FETCH and clear trap_cause to 00; instret unchanged.
REQ-028 mem_ready outside FETCH/MEMORY SHALL be ignored.
REQ-029 instret SHALL wrap from 2^CNT_W-1 to 0 without a flag.

Reset
REQ-030 While reset=0, regardless of clk: state=FETCH, class=R, wait counter=0, instret=0, trap_cause=00.
REQ-031 The resulting outputs SHALL be mem_read=1 and all other strobes, trap and alu_op 0.
REQ-032 Reset asserted mid-access SHALL abort the access immediately; after release, operation SHALL restart at FETCH.

Verification
REQ-033 opcode=0110011, mem_ready=1 always -> states 0,1,2,4,0; reg_write and pc_write high in the 4th cycle; instret 0->1.
REQ-034 LOAD with mem_ready low 3 cycles in MEMORY -> mem_read held 4 MEMORY cycles, then WRITEBACK with mem2reg=1; instret increments once.
REQ-035 STORE, mem_ready=1 -> mem_write=1 and pc_write=1 in the same MEMORY cycle, then FETCH; reg_write never asserted.
REQ-036 opcode=1111111 -> TRAP with trap_cause=01; trap_clear=1 -> FETCH with trap_cause=00.
REQ-037 TIMEOUT=15, mem_ready=0 in FETCH -> TRAP with cause 10 after 15 waiting cycles; a second run with mem_ready at cycle 15 -> DECODE, no trap.
REQ-038 CNT_W=4, 16 retired R-type instructions -> instret wraps to 0; reset pulsed in MEMORY -> state=0 asynchronously and instret=0.
